// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped 8N1 serial port: bus addresses,
// frame shape and the TX/RX state encodings.
package uart_mmio_pkg;

    localparam logic [31:0] SERIAL_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] SERIAL_STAT_ADDR = 32'hBFD0_03FC;

    localparam int   FRAME_DATA_BITS = 8;
    localparam int   BIT_IDX_W       = $clog2(FRAME_DATA_BITS);
    localparam logic LINE_IDLE       = 1'b1;
    localparam logic START_BIT       = 1'b0;
    localparam logic STOP_BIT        = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // RX_BREAK parks the receiver after a bad stop bit until the line idles high.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; dout is the head entry combinationally.
// Push when full and pop when empty are ignored; push+pop together keeps count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/uart_mmio.sv
// Serial port on the MEM-stage bus: DATA/STAT registers over TX/RX FIFOs and 8N1 line FSMs.
// Reads are combinational; a full TX FIFO drops writes, a full RX FIFO drops bytes and flags overrun.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int CLK_FREQ   = 59000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] serial_data_o,
    output logic [1:0]  state,
    output logic        txd,
    input  logic        rxd
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]        BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]        HALF_BIT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [BIT_IDX_W-1:0] LAST_DBIT = BIT_IDX_W'(FRAME_DATA_BITS - 1);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe <= 2'b00;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic unused_wdata;
    assign unused_wdata = ^mem_data_i[31:8];

    logic hit_data, hit_stat;
    logic tx_push, rx_pop, ovr_clr;

    assign hit_data = mem_ce_i && (mem_addr_i == SERIAL_DATA_ADDR);
    assign hit_stat = mem_ce_i && (mem_addr_i == SERIAL_STAT_ADDR);
    assign tx_push  = hit_data && mem_we;
    assign rx_pop   = hit_data && !mem_we;
    assign ovr_clr  = hit_stat && !mem_we;

    logic [FRAME_DATA_BITS-1:0] tx_dout, rx_dout, rx_shreg, tx_shreg;
    logic tx_full, tx_empty, tx_pop;
    logic rx_full, rx_empty, rx_push;
    logic overrun, ovr_set;

    sync_fifo #(.WIDTH(FRAME_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (mem_data_i[FRAME_DATA_BITS-1:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(FRAME_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_shreg),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        serial_data_o = 32'h0;
        if (mem_addr_i == SERIAL_DATA_ADDR)
            serial_data_o = {24'h0, rx_empty ? 8'h00 : rx_dout};
        else if (mem_addr_i == SERIAL_STAT_ADDR)
            serial_data_o = {29'h0, overrun, !rx_empty, !tx_full};
    end

    assign state = {!rx_empty, !tx_full};

    // ---------------- transmitter ----------------
    tx_state_t            tx_state, tx_next;
    logic [CW-1:0]        tx_cnt;
    logic [BIT_IDX_W-1:0] tx_bit;
    logic                 tx_expire;

    assign tx_expire = (tx_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_next = TX_START;
            TX_START: if (tx_expire) tx_next = TX_DATA;
            TX_DATA:  if (tx_expire && tx_bit == LAST_DBIT) tx_next = TX_STOP;
            TX_STOP:  if (tx_expire) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        txd    = LINE_IDLE;
        tx_pop = 1'b0;
        case (tx_state)
            TX_IDLE:  tx_pop = !tx_empty;
            TX_START: txd    = START_BIT;
            TX_DATA:  txd    = tx_shreg[0];
            TX_STOP:  txd    = STOP_BIT;
            default:  txd    = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else if (tx_state == TX_IDLE) begin
            tx_cnt <= BIT_LAST;
            tx_bit <= '0;
            if (!tx_empty) tx_shreg <= tx_dout;
        end else if (tx_expire) begin
            tx_cnt <= BIT_LAST;
            if (tx_state == TX_DATA) begin
                tx_shreg <= tx_shreg >> 1;
                tx_bit   <= tx_bit + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt - 1'b1;
        end
    end

    // ---------------- receiver ----------------
    logic rxd_meta, rxd_sync, rxd_prev, rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end
    assign rx_fall = rxd_prev && !rxd_sync;

    rx_state_t            rx_state, rx_next;
    logic [CW-1:0]        rx_cnt;
    logic [BIT_IDX_W-1:0] rx_bit;
    logic                 rx_expire;

    assign rx_expire = (rx_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_expire) rx_next = (rxd_sync == START_BIT) ? RX_DATA : RX_IDLE;
            RX_DATA:  if (rx_expire && rx_bit == LAST_DBIT) rx_next = RX_STOP;
            RX_STOP:  if (rx_expire) rx_next = (rxd_sync == STOP_BIT) ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rxd_sync == LINE_IDLE) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push = 1'b0;
        ovr_set = 1'b0;
        if (rx_state == RX_STOP && rx_expire && rxd_sync == STOP_BIT) begin
            rx_push = !rx_full;
            ovr_set = rx_full;
        end
    end

    // Idle preloads half a bit so later samples land mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= HALF_BIT;
                    rx_bit <= '0;
                end
                RX_BREAK: rx_cnt <= rx_cnt;
                default: begin
                    if (rx_expire) begin
                        rx_cnt <= BIT_LAST;
                        if (rx_state == RX_DATA) begin
                            rx_shreg <= {rxd_sync, rx_shreg[FRAME_DATA_BITS-1:1]};
                            rx_bit   <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overrun <= 1'b0;
        else if (ovr_set) overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized bench for uart_mmio at 8 clocks per bit, checked against a queue-based model.
module tb_uart_mmio;
    import uart_mmio_pkg::*;

    localparam logic [31:0] A_DATA = 32'hBFD0_03F8;
    localparam logic [31:0] A_STAT = 32'hBFD0_03FC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ce_i = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_data_i = 32'h0;
    logic [31:0] serial_data_o;
    logic [1:0]  state;
    logic        txd;
    logic        rxd = 1'b1;

    uart_mmio #(.CLK_FREQ(8), .BAUD(1), .FIFO_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_ce_i      (mem_ce_i),
        .mem_we        (mem_we),
        .mem_addr_i    (mem_addr_i),
        .mem_data_i    (mem_data_i),
        .serial_data_o (serial_data_o),
        .state         (state),
        .txd           (txd),
        .rxd           (rxd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_model[$];
    logic [7:0] tx_model[$];
    logic       ovr_model = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        mem_ce_i = 1'b1; mem_we = 1'b1; mem_addr_i = addr; mem_data_i = data;
        @(negedge clk);
        mem_ce_i = 1'b0; mem_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
        mem_ce_i = 1'b1; mem_we = 1'b0; mem_addr_i = addr;
        #1 d = serial_data_o;
        @(negedge clk);
        mem_ce_i = 1'b0;
    endtask

    task automatic read_stat_chk(input string tag);
        logic [31:0] d;
        bus_read(A_STAT, d);
        check(tag, d, {29'h0, ovr_model, rx_model.size() != 0, 1'b1});
        ovr_model = 1'b0;
    endtask

    task automatic read_data_chk(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        bus_read(A_DATA, d);
        exp = 32'h0;
        if (rx_model.size() != 0) exp = {24'h0, rx_model.pop_front()};
        check(tag, d, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (8) @(negedge clk);
        end
        check("rx_pre_stop_state", {31'h0, state[1]}, {31'h0, rx_model.size() != 0});
        rxd = stop;
        repeat (8) @(negedge clk);
        if (stop) begin
            if (rx_model.size() < 16) rx_model.push_back(b);
            else ovr_model = 1'b1;
        end
    endtask

    task automatic decode_tx(output logic [7:0] b);
        int n;
        n = 0;
        b = 8'h0;
        while (txd !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (txd !== 1'b0) begin
            check("tx_frame_start", {31'h0, txd}, 32'h0);
            return;
        end
        repeat (4) @(negedge clk);
        check("tx_start_mid", {31'h0, txd}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(negedge clk);
            b[i] = txd;
        end
        repeat (8) @(negedge clk);
        check("tx_stop_bit", {31'h0, txd}, 32'h1);
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic [7:0]  a5;
        int          n;
        int          lows;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        check("reset_txd", {31'h0, txd}, 32'h1);
        check("reset_state", {30'h0, state}, 32'h1);
        bus_read(A_STAT, d);
        check("reset_stat", d, 32'h1);

        // Exact waveform of one frame; upper write-data bits must be ignored.
        a5 = 8'hA5;
        bus_write(A_DATA, 32'hFFFF_FFA5);
        n = 0;
        while (txd !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("a5_start_latency", n, 1);
        for (int k = 0; k < 80; k++) begin
            logic exp_bit;
            if (k < 8)       exp_bit = 1'b0;
            else if (k < 72) exp_bit = a5[(k - 8) / 8];
            else             exp_bit = 1'b1;
            check($sformatf("a5_wave_%0d", k), {31'h0, txd}, {31'h0, exp_bit});
            @(negedge clk);
        end
        check("a5_idle_after", {31'h0, txd}, 32'h1);

        // Accesses that must have no side effects.
        mem_ce_i = 1'b0; mem_we = 1'b1; mem_addr_i = A_DATA; mem_data_i = 32'h12;
        @(negedge clk);
        mem_we = 1'b0;
        bus_write(A_STAT, 32'h55);
        bus_write(32'hBFD0_03F4, 32'h66);
        bus_read(32'hBFD0_03F4, d);
        check("other_addr_read", d, 32'h0);
        count_low(120, lows);
        check("no_spurious_tx", lows, 0);

        // TX overflow: park 0xFF in the shifter, then overfill the FIFO.
        bus_write(A_DATA, 32'hFF);
        repeat (2) @(negedge clk);
        for (int i = 0; i <= 16; i++) begin
            bus_write(A_DATA, i);
            if (tx_model.size() < 16) tx_model.push_back(8'(i));
            check($sformatf("tx_not_full_%0d", i), {31'h0, state[0]}, {31'h0, tx_model.size() < 16});
        end
        while (tx_model.size() != 0) begin
            decode_tx(b);
            check("tx_ovf_byte", {24'h0, b}, {24'h0, tx_model.pop_front()});
        end
        count_low(200, lows);
        check("tx_ovf_dropped", lows, 0);
        bus_read(A_STAT, d);
        check("tx_drained_stat", d, 32'h1);

        // RX of 0x3C, then drain.
        send_frame(8'h3C, 1'b1);
        check("rx_3c_state", {31'h0, state[1]}, {31'h0, rx_model.size() != 0});
        read_data_chk("rx_3c_data");
        check("rx_3c_drained", {31'h0, state[1]}, {31'h0, rx_model.size() != 0});
        read_data_chk("rx_empty_read");

        // Short low pulse must be rejected.
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_push", {31'h0, state[1]}, 32'h0);
        check("glitch_idle", {31'h0, dut.rx_state == RX_IDLE}, 32'h1);

        // Framing error: receiver waits for the line to return high.
        send_frame(8'($urandom), 1'b0);
        repeat (16) @(negedge clk);
        check("ferr_busy", {31'h0, dut.rx_state == RX_IDLE}, 32'h0);
        check("ferr_no_push", {31'h0, state[1]}, 32'h0);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_idle", {31'h0, dut.rx_state == RX_IDLE}, 32'h1);
        send_frame(8'($urandom), 1'b1);
        read_data_chk("ferr_recover");

        // Random mix of transmit and receive traffic.
        for (int it = 0; it < 8; it++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] got;
                bus_write(A_DATA, {24'($urandom), b});
                decode_tx(got);
                check("rand_tx", {24'h0, got}, {24'h0, b});
            end else begin
                send_frame(b, 1'b1);
                read_stat_chk("rand_rx_stat");
                read_data_chk("rand_rx_data");
            end
        end
        repeat (20) @(negedge clk);

        // Overrun: 17 frames into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b1);
        read_stat_chk("ovr_stat_first");
        read_stat_chk("ovr_stat_second");
        for (int i = 0; i < 16; i++) read_data_chk($sformatf("ovr_data_%0d", i));
        read_data_chk("ovr_data_empty");
        read_stat_chk("ovr_stat_final");

        // Reset in the middle of a frame.
        for (int i = 0; i < 3; i++) bus_write(A_DATA, $urandom);
        n = 0;
        while (txd !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rst_async_txd", {31'h0, txd}, 32'h1);
        rx_model.delete();
        ovr_model = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        read_stat_chk("rst_stat");
        count_low(200, lows);
        check("rst_fifo_flushed", lows, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
